stack_alu_unit: RTL and testbench

STACK_ALU_UNIT -- requirements
Module: stack_alu_unit

---
 rtl/stack_alu_unit.sv | 119 +++++++++++
 tb/tb_stack_alu_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/stack_alu_unit.sv
// stack_alu_unit: register stack with ADD/SUB/AND/NOT/PUSH/POP, one request at a time
// Ports: clk, rst (async, active-high); start/op/din request inputs sampled in IDLE;
//        dout (last popped value), tos (top of stack, 0 when empty), count (valid entries);
//        busy (request executing), done (completion pulse), err (request rejected, with done);
//        zero (result/popped value was zero); full/empty decoded from count.
module stack_alu_unit #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic [DW-1:0]              tos,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       zero,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                           OP_NOT = 3'b011, OP_PUSH = 3'b100, OP_POP = 3'b101;

    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_n;

    logic [2:0]    op_r;
    logic [DW-1:0] din_r;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] t_idx, b_idx, w_idx;
    logic [DW-1:0] a, b, res;
    logic [CW-1:0] count_n;
    logic          bad, we;

    // Indices wrap when the stack is too shallow; those cases are always rejected.
    assign t_idx = AW'(count - CW'(1));
    assign b_idx = AW'(count - CW'(2));
    assign a     = mem[b_idx];
    assign b     = mem[t_idx];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign tos   = empty ? '0 : b;
    assign busy  = state == EXEC;
    assign we    = busy && !bad && op_r != OP_POP;

    always_comb begin
        state_n = (state == IDLE) ? (start ? EXEC : IDLE) : IDLE;
    end

    always_comb begin
        res     = '0;
        bad     = 1'b1;
        count_n = count;
        w_idx   = AW'(count);
        case (op_r)
            OP_ADD, OP_SUB, OP_AND: begin
                bad     = count < CW'(2);
                res     = (op_r == OP_ADD) ? a + b : (op_r == OP_SUB) ? a - b : a & b;
                count_n = count - CW'(1);
                w_idx   = b_idx;
            end
            OP_NOT: begin
                bad   = empty;
                res   = ~b;
                w_idx = t_idx;
            end
            OP_PUSH: begin
                bad     = full;
                res     = din_r;
                count_n = count + CW'(1);
            end
            OP_POP: begin
                bad     = empty;
                res     = b;
                count_n = count - CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            dout  <= '0;
            zero  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            op_r  <= '0;
            din_r <= '0;
        end else begin
            done <= busy;
            err  <= busy && bad;
            if (state == IDLE && start) begin
                op_r  <= op;
                din_r <= din;
            end
            if (busy && !bad) begin
                count <= count_n;
                zero  <= res == '0;
                if (op_r == OP_POP) dout <= res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[w_idx] <= res;
    end
endmodule

// File: tb/tb_stack_alu_unit.sv
// tb_stack_alu_unit: directed-vector self-checking bench for stack_alu_unit
module tb_stack_alu_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [7:0] din = '0;
    logic [7:0] dout, tos;
    logic [3:0] count;
    logic       busy, done, err, zero, full, empty;
    int         n_chk = 0;
    int         n_pass = 0;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, NOT = 3'b011,
                           PUSH = 3'b100, POP = 3'b101, ILL = 3'b110;

    stack_alu_unit #(.DW(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .din(din),
        .dout(dout), .tos(tos), .count(count), .busy(busy), .done(done),
        .err(err), .zero(zero), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle so the
    // next call issues its request back-to-back.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] d, input logic e);
        start = 1'b1;
        op    = o;
        din   = d;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, busy, 1);
        check({tag, ".early_done"}, done, 0);
        @(negedge clk);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy_off"}, busy, 0);
        check({tag, ".err"}, err, e);
    endtask

    initial begin
        @(negedge clk);
        #1;
        check("rst.count", count, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.dout", dout, 0);
        check("rst.zero", zero, 0);
        check("rst.empty", empty, 1);
        check("rst.tos", tos, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op("push08a", PUSH, 8'h08, 0);
        check("push08a.zero", zero, 0);
        do_op("push08b", PUSH, 8'h08, 0);
        do_op("add", ADD, 8'h00, 0);
        check("add.count", count, 1);
        check("add.tos", tos, 8'h10);
        check("add.zero", zero, 0);

        do_op("push10", PUSH, 8'h10, 0);
        do_op("sub", SUB, 8'h00, 0);
        check("sub.tos", tos, 8'h00);
        check("sub.zero", zero, 1);
        check("sub.count", count, 1);
        do_op("pushAA", PUSH, 8'hAA, 0);
        do_op("push66", PUSH, 8'h66, 0);
        check("push66.count", count, 3);
        do_op("and", AND, 8'h00, 0);
        check("and.tos", tos, 8'h22);
        check("and.zero", zero, 0);
        do_op("not", NOT, 8'h00, 0);
        check("not.tos", tos, 8'hDD);
        check("not.count", count, 2);

        do_op("pop1", POP, 8'h00, 0);
        check("pop1.dout", dout, 8'hDD);
        check("pop1.count", count, 1);
        check("pop1.zero", zero, 0);
        do_op("pop2", POP, 8'h00, 0);
        check("pop2.dout", dout, 8'h00);
        check("pop2.zero", zero, 1);
        check("pop2.empty", empty, 1);
        check("pop2.tos", tos, 0);
        do_op("pop_empty", POP, 8'h00, 1);
        check("pop_empty.dout", dout, 8'h00);
        check("pop_empty.count", count, 0);
        check("pop_empty.zero", zero, 1);
        do_op("not_empty", NOT, 8'h00, 1);
        check("not_empty.count", count, 0);

        for (int i = 1; i <= 8; i++) begin
            do_op("fill", PUSH, 8'(i), 0);
            check("fill.tos", tos, i);
            check("fill.full", full, i == 8);
        end
        do_op("push_full", PUSH, 8'hFF, 1);
        check("push_full.tos", tos, 8'h08);
        check("push_full.count", count, 8);
        for (int i = 8; i >= 1; i--) begin
            do_op("drain", POP, 8'h00, 0);
            check("drain.dout", dout, i);
        end
        check("drain.empty", empty, 1);
        do_op("pushFF", PUSH, 8'hFF, 0);
        do_op("push02", PUSH, 8'h02, 0);
        do_op("add_wrap", ADD, 8'h00, 0);
        check("add_wrap.tos", tos, 8'h01);
        check("add_wrap.zero", zero, 0);

        do_op("add_short", ADD, 8'h00, 1);
        check("add_short.tos", tos, 8'h01);
        check("add_short.count", count, 1);
        do_op("illegal", ILL, 8'h00, 1);
        check("illegal.count", count, 1);
        check("illegal.tos", tos, 8'h01);

        start = 1'b1;
        op    = PUSH;
        din   = 8'h77;
        @(negedge clk);
        check("busy_start.busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        check("busy_start.done", done, 1);
        check("busy_start.count", count, 2);
        @(negedge clk);
        check("busy_start.no_done", done, 0);
        check("busy_start.idle", busy, 0);
        check("busy_start.count2", count, 2);
        do_op("pop77", POP, 8'h00, 0);
        check("pop77.dout", dout, 8'h77);

        @(negedge clk);
        start = 1'b1;
        op    = PUSH;
        din   = 8'h55;
        @(negedge clk);
        start = 1'b0;
        check("rst_exec.busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_exec.busy_off", busy, 0);
        check("rst_exec.count", count, 0);
        check("rst_exec.dout", dout, 0);
        check("rst_exec.zero", zero, 0);
        check("rst_exec.done", done, 0);
        check("rst_exec.err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_exec.no_done", done, 0);
        check("rst_exec.count_rel", count, 0);
        @(negedge clk);
        check("rst_exec.still_no_done", done, 0);
        do_op("push33", PUSH, 8'h33, 0);
        check("push33.tos", tos, 8'h33);
        check("push33.count", count, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
